// File: rtl/score_tracker.sv
// score_tracker: packed-BCD running score with an internal tick divider,
// a high-score register, a difficulty level for the engine and
// leading-zero blanking for the HEX display bank.
module score_tracker #(
  parameter int DIGITS    = 6,
  parameter int TICK_DIV  = 5000000,
  parameter int LEVEL_PTS = 100,
  parameter int MAX_LEVEL = 7,
  parameter int LEVEL_W   = 3
) (
  input  logic                clk50MHz,
  input  logic                reset,
  input  logic                newGame,
  input  logic                running,
  input  logic                pause,
  input  logic                showHigh,
  output logic [4*DIGITS-1:0] scoreBCD,
  output logic [DIGITS-1:0]   blankMask,
  output logic [LEVEL_W-1:0]  level,
  output logic                newRecord,
  output logic                saturated
);

  localparam int SW    = 4 * DIGITS;
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PTS_W = (LEVEL_PTS > 1) ? $clog2(LEVEL_PTS) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST    = DIV_W'(TICK_DIV - 1);
  localparam logic [PTS_W-1:0]   PTS_LAST    = PTS_W'(LEVEL_PTS - 1);
  localparam logic [LEVEL_W-1:0] LEVEL_TOP   = LEVEL_W'(MAX_LEVEL);
  localparam logic [SW-1:0]      ALL_NINES   = {DIGITS{4'h9}};
  localparam logic [DIGITS-1:0]  BLANK_RESET = ~DIGITS'(1);

  // Internal state
  logic [SW-1:0]      cur_q, cur_d;
  logic [SW-1:0]      high_q, high_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [PTS_W-1:0]   pts_q, pts_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               run_q, run_d;
  logic               sat_q, sat_d;
  logic               rec_q, rec_d;
  logic [SW-1:0]      disp_q, disp_d;
  logic [DIGITS-1:0]  blank_q, blank_d;

  // Combinational helpers
  logic          en;
  logic          tick;
  logic          end_evt;
  logic          beats_high;
  logic [SW-1:0] inc_val;
  logic          carry;
  logic [SW-1:0] sel_val;
  logic          zero_above;

  // Counting is enabled only while playing, unpaused and not yet at all 9s.
  always_comb begin
    en         = running & ~pause & ~sat_q;
    tick       = en & (div_q == DIV_LAST);
    end_evt    = run_q & ~running;
    beats_high = end_evt & (cur_q > high_q);
  end

  // Ripple BCD increment of the current score: a 9 rolls to 0 and carries on.
  always_comb begin
    inc_val = cur_q;
    carry   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (cur_q[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = cur_q[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
  end

  // Next state for score, divider, level, high score and record pulse; newGame beats tick.
  always_comb begin
    cur_d   = cur_q;
    high_d  = high_q;
    div_d   = div_q;
    pts_d   = pts_q;
    level_d = level_q;
    run_d   = running;
    rec_d   = beats_high;

    if (beats_high) begin
      high_d = cur_q;
    end

    if (newGame) begin
      cur_d   = '0;
      div_d   = '0;
      pts_d   = '0;
      level_d = '0;
    end else if (tick) begin
      cur_d = inc_val;
      div_d = '0;
      if (pts_q == PTS_LAST) begin
        pts_d = '0;
        if (level_q < LEVEL_TOP) begin
          level_d = level_q + 1'b1;
        end
      end else begin
        pts_d = pts_q + 1'b1;
      end
    end else if (en) begin
      div_d = div_q + 1'b1;
    end

    sat_d = (cur_d == ALL_NINES);
  end

  // Display select and leading-zero blanking, computed from the internal registers.
  always_comb begin
    sel_val    = showHigh ? high_q : cur_q;
    disp_d     = sel_val;
    blank_d    = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (sel_val[4*i +: 4] == 4'd0);
      blank_d[i] = zero_above;
    end
  end

  // All state registers, cleared asynchronously (high score included).
  always_ff @(posedge clk50MHz or posedge reset) begin
    if (reset) begin
      cur_q   <= '0;
      high_q  <= '0;
      div_q   <= '0;
      pts_q   <= '0;
      level_q <= '0;
      run_q   <= 1'b0;
      sat_q   <= 1'b0;
      rec_q   <= 1'b0;
      disp_q  <= '0;
      blank_q <= BLANK_RESET;
    end else begin
      cur_q   <= cur_d;
      high_q  <= high_d;
      div_q   <= div_d;
      pts_q   <= pts_d;
      level_q <= level_d;
      run_q   <= run_d;
      sat_q   <= sat_d;
      rec_q   <= rec_d;
      disp_q  <= disp_d;
      blank_q <= blank_d;
    end
  end

  assign scoreBCD  = disp_q;
  assign blankMask = blank_q;
  assign level     = level_q;
  assign newRecord = rec_q;
  assign saturated = sat_q;

endmodule
